// File: rtl/flash_spi_arbiter_if.sv
// Pin bundle between the two SPI masters, the arbiter and the flash pin driver.
// The slave view belongs to the arbiter; the master view belongs to the
// surrounding system (both SPI masters plus the flash pad side).
interface flash_spi_arbiter_if;
  // Requester A (core EEPROM port)
  logic a_req;
  logic a_grant;
  logic a_csn;
  logic a_sck;
  logic a_mosi;
  logic a_holdn;
  logic a_wpn;
  logic a_miso;
  // Requester B (boot / image loader path)
  logic b_req;
  logic b_grant;
  logic b_csn;
  logic b_sck;
  logic b_mosi;
  logic b_holdn;
  logic b_wpn;
  logic b_miso;
  // Flash pin driver side
  logic flash_csn;
  logic flash_sck;
  logic flash_mosi;
  logic flash_holdn;
  logic flash_wpn;
  logic flash_miso;
  // Status
  logic busy;

  modport slave (
    input  a_req, a_csn, a_sck, a_mosi, a_holdn, a_wpn,
    output a_grant, a_miso,
    input  b_req, b_csn, b_sck, b_mosi, b_holdn, b_wpn,
    output b_grant, b_miso,
    output flash_csn, flash_sck, flash_mosi, flash_holdn, flash_wpn,
    input  flash_miso,
    output busy
  );

  modport master (
    output a_req, a_csn, a_sck, a_mosi, a_holdn, a_wpn,
    input  a_grant, a_miso,
    output b_req, b_csn, b_sck, b_mosi, b_holdn, b_wpn,
    input  b_grant, b_miso,
    input  flash_csn, flash_sck, flash_mosi, flash_holdn, flash_wpn,
    output flash_miso,
    input  busy
  );
endinterface

// File: rtl/flash_spi_arbiter.sv
// Two-master arbiter for the on-board SPI config flash.
// Ownership only moves at a transaction boundary (owner's req low and csn high),
// followed by a forced csn-high gap, so neither master can corrupt the other.
// Flash pins are registered copies of the owner's pins (one cycle of delay).
module flash_spi_arbiter #(
  parameter int C_idle_min = 4,
  parameter int C_rr       = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  flash_spi_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(C_idle_min) + 1;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(C_idle_min - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic             RR_EN    = (C_rr != 0);

  // Pin bundle order: {csn, sck, mosi, holdn, wpn}; idle = deselected, clock low,
  // hold and write-protect released.
  localparam logic [4:0] PINS_IDLE = 5'b10011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             last_b_q, last_b_d;     // 1 = B was served last
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_grant_q, a_grant_d;
  logic             b_grant_q, b_grant_d;
  logic             busy_q, busy_d;
  logic [4:0]       flash_pins_q, flash_pins_d;

  logic [4:0]       a_pins_s;
  logic [4:0]       b_pins_s;
  logic             pick_b_s;

  assign a_pins_s = {bus.a_csn, bus.a_sck, bus.a_mosi, bus.a_holdn, bus.a_wpn};
  assign b_pins_s = {bus.b_csn, bus.b_sck, bus.b_mosi, bus.b_holdn, bus.b_wpn};

  // B wins when it is the only requester, or on a tie in round-robin mode when
  // A was the last one served. With fixed priority A takes every tie.
  assign pick_b_s = bus.b_req && (!bus.a_req || (RR_EN && !last_b_q));

  // Next-state, grant and pin-forwarding decisions for the ownership FSM.
  always_comb begin
    state_d      = state_q;
    last_b_d     = last_b_q;
    cnt_d        = cnt_q;
    a_grant_d    = 1'b0;
    b_grant_d    = 1'b0;
    flash_pins_d = PINS_IDLE;

    case (state_q)
      ST_IDLE: begin
        if (bus.a_req || bus.b_req) begin
          if (pick_b_s) begin
            state_d   = ST_OWN_B;
            b_grant_d = 1'b1;
            last_b_d  = 1'b1;
          end else begin
            state_d   = ST_OWN_A;
            a_grant_d = 1'b1;
            last_b_d  = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_OWN_A: begin
        // Release only at a clean boundary; a dropped req with csn still low
        // keeps the grant so the transaction finishes untouched.
        if (!bus.a_req && bus.a_csn) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          a_grant_d    = 1'b1;
          flash_pins_d = a_pins_s;
        end
      end

      ST_OWN_B: begin
        if (!bus.b_req && bus.b_csn) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          b_grant_d    = 1'b1;
          flash_pins_d = b_pins_s;
        end
      end

      ST_GAP: begin
        // Requests arriving here wait; they are re-arbitrated from IDLE.
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Ownership FSM state and every registered output, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_b_q     <= 1'b1;
      cnt_q        <= CNT_ZERO;
      a_grant_q    <= 1'b0;
      b_grant_q    <= 1'b0;
      busy_q       <= 1'b0;
      flash_pins_q <= PINS_IDLE;
    end else begin
      state_q      <= state_d;
      last_b_q     <= last_b_d;
      cnt_q        <= cnt_d;
      a_grant_q    <= a_grant_d;
      b_grant_q    <= b_grant_d;
      busy_q       <= busy_d;
      flash_pins_q <= flash_pins_d;
    end
  end

  // Return path: only the owner sees flash data, everyone else reads idle-high.
  always_comb begin
    if (state_q == ST_OWN_A) begin
      bus.a_miso = bus.flash_miso;
    end else begin
      bus.a_miso = 1'b1;
    end
    if (state_q == ST_OWN_B) begin
      bus.b_miso = bus.flash_miso;
    end else begin
      bus.b_miso = 1'b1;
    end
  end

  assign bus.a_grant     = a_grant_q;
  assign bus.b_grant     = b_grant_q;
  assign bus.busy        = busy_q;
  assign bus.flash_csn   = flash_pins_q[4];
  assign bus.flash_sck   = flash_pins_q[3];
  assign bus.flash_mosi  = flash_pins_q[2];
  assign bus.flash_holdn = flash_pins_q[1];
  assign bus.flash_wpn   = flash_pins_q[0];

endmodule

// File: tb/tb_flash_spi_arbiter.sv
// Bench for flash_spi_arbiter: a round-robin and a fixed-priority instance
// share the same stimulus and are compared every cycle against a reference
// model built from owner / gap-length / last-served bookkeeping.
module tb_flash_spi_arbiter;

  localparam int         C_IDLE    = 4;
  localparam logic [4:0] PINS_IDLE = 5'b10011;  // {csn,sck,mosi,holdn,wpn}

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, b_req, flash_miso;
  logic [4:0] a_pins, b_pins;
  logic       toggle_b;

  int checks   = 0;
  int failures = 0;

  // Reference model state, index 0 = round-robin, 1 = fixed priority.
  // owner: 0 none, 1 A, 2 B.  gap: forced-idle cycles still to run.
  int         m_owner [2];
  int         m_gap   [2];
  int         m_last  [2];
  logic [4:0] m_pins  [2];

  always #5 clk = ~clk;

  flash_spi_arbiter_if bus_rr ();
  flash_spi_arbiter_if bus_fp ();

  flash_spi_arbiter #(.C_idle_min(C_IDLE), .C_rr(1)) dut_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_rr.slave)
  );

  flash_spi_arbiter #(.C_idle_min(C_IDLE), .C_rr(0)) dut_fp (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_fp.slave)
  );

  assign bus_rr.a_req = a_req;
  assign bus_rr.b_req = b_req;
  assign bus_rr.flash_miso = flash_miso;
  assign {bus_rr.a_csn, bus_rr.a_sck, bus_rr.a_mosi, bus_rr.a_holdn, bus_rr.a_wpn} = a_pins;
  assign {bus_rr.b_csn, bus_rr.b_sck, bus_rr.b_mosi, bus_rr.b_holdn, bus_rr.b_wpn} = b_pins;
  assign bus_fp.a_req = a_req;
  assign bus_fp.b_req = b_req;
  assign bus_fp.flash_miso = flash_miso;
  assign {bus_fp.a_csn, bus_fp.a_sck, bus_fp.a_mosi, bus_fp.a_holdn, bus_fp.a_wpn} = a_pins;
  assign {bus_fp.b_csn, bus_fp.b_sck, bus_fp.b_mosi, bus_fp.b_holdn, bus_fp.b_wpn} = b_pins;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_owner[i] = 0;
        m_gap[i]   = 0;
        m_last[i]  = 2;
        m_pins[i]  = PINS_IDLE;
      end else if (m_owner[i] != 0) begin
        logic       req;
        logic [4:0] p;
        req = (m_owner[i] == 1) ? a_req  : b_req;
        p   = (m_owner[i] == 1) ? a_pins : b_pins;
        if (!req && p[4]) begin
          m_owner[i] = 0;
          m_gap[i]   = C_IDLE;
          m_pins[i]  = PINS_IDLE;
        end else begin
          m_pins[i] = p;
        end
      end else if (m_gap[i] > 0) begin
        m_gap[i]  = m_gap[i] - 1;
        m_pins[i] = PINS_IDLE;
      end else begin
        m_pins[i] = PINS_IDLE;
        if (a_req || b_req) begin
          int w;
          if (a_req && b_req) w = (i == 0) ? ((m_last[i] == 1) ? 2 : 1) : 1;
          else                w = a_req ? 1 : 2;
          m_owner[i] = w;
          m_last[i]  = w;
        end
      end
    end
  endtask

  function automatic logic [9:0] exp_vec(input int i);
    return {m_owner[i] == 1, m_owner[i] == 2, (m_owner[i] != 0) || (m_gap[i] > 0),
            m_pins[i],
            (m_owner[i] == 1) ? flash_miso : 1'b1,
            (m_owner[i] == 2) ? flash_miso : 1'b1};
  endfunction

  // One clock: optional non-owner noise, random flash data, model, edge, compare.
  task automatic cyc(input string tag);
    if (toggle_b) b_pins[4:2] = ~b_pins[4:2];
    flash_miso = 1'($urandom_range(0, 1));
    model_step();
    @(posedge clk);
    #1;
    check({"rr_", tag}, 32'({bus_rr.a_grant, bus_rr.b_grant, bus_rr.busy,
          bus_rr.flash_csn, bus_rr.flash_sck, bus_rr.flash_mosi,
          bus_rr.flash_holdn, bus_rr.flash_wpn, bus_rr.a_miso, bus_rr.b_miso}),
          32'(exp_vec(0)));
    check({"fp_", tag}, 32'({bus_fp.a_grant, bus_fp.b_grant, bus_fp.busy,
          bus_fp.flash_csn, bus_fp.flash_sck, bus_fp.flash_mosi,
          bus_fp.flash_holdn, bus_fp.flash_wpn, bus_fp.a_miso, bus_fp.b_miso}),
          32'(exp_vec(1)));
  endtask

  // A shifts one byte MSB first at clk/4: two cycles sck low, two cycles high.
  task automatic a_send_byte(input logic [7:0] v);
    for (int k = 7; k >= 0; k--) begin
      a_pins[2] = v[k];
      a_pins[3] = 1'b0;
      cyc("spi_lo");
      cyc("spi_lo");
      a_pins[3] = 1'b1;
      cyc("spi_hi");
      cyc("spi_hi");
    end
  endtask

  task automatic idle_inputs();
    a_req  = 1'b0;
    b_req  = 1'b0;
    a_pins = PINS_IDLE;
    b_pins = PINS_IDLE;
  endtask

  initial begin
    toggle_b   = 1'b0;
    flash_miso = 1'b1;
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = 0;
      m_gap[i]   = 0;
      m_last[i]  = 2;
      m_pins[i]  = PINS_IDLE;
    end

    // Reset for three cycles, then confirm the quiet state.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cyc("reset");
    check("rst_flash_csn", 32'(bus_rr.flash_csn), 32'd1);
    check("rst_flash_sck", 32'(bus_rr.flash_sck), 32'd0);
    check("rst_holdn_wpn", 32'({bus_rr.flash_holdn, bus_rr.flash_wpn}), 32'd3);
    check("rst_grants_busy", 32'({bus_rr.a_grant, bus_rr.b_grant, bus_rr.busy}), 32'd0);
    check("rst_misos", 32'({bus_rr.a_miso, bus_rr.b_miso}), 32'd3);
    reset = 1'b0;
    cyc("idle");

    // Single A read command while B toggles its pins without requesting.
    a_req = 1'b1;
    cyc("a_req");
    check("a_grant_latency", 32'(bus_rr.a_grant), 32'd1);
    toggle_b  = 1'b1;
    a_pins[4] = 1'b0;
    cyc("a_csn_low");
    a_send_byte(8'h03);
    a_send_byte(8'h12);
    a_send_byte(8'h34);
    a_send_byte(8'h56);
    check("iso_b_grant", 32'(bus_rr.b_grant), 32'd0);
    a_pins[3] = 1'b0;
    cyc("a_sck_low");
    a_pins[4] = 1'b1;
    a_req     = 1'b0;
    toggle_b  = 1'b0;
    cyc("a_release");
    check("a_release_grant", 32'(bus_rr.a_grant), 32'd0);
    check("gap_csn_high", 32'(bus_rr.flash_csn), 32'd1);
    for (int i = 0; i < 3; i++) cyc("gap");
    check("gap_busy", 32'(bus_rr.busy), 32'd1);
    cyc("gap_end");
    check("idle_busy", 32'(bus_rr.busy), 32'd0);
    cyc("idle");

    // Early req drop: grant and forwarding held until csn returns high.
    a_req = 1'b1;
    cyc("ed_req");
    a_pins[4] = 1'b0;
    cyc("ed_csn");
    a_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a_pins[2] = 1'($urandom_range(0, 1));
      a_pins[3] = 1'(i % 2);
      cyc("ed_hold");
    end
    check("ed_grant_held", 32'(bus_rr.a_grant), 32'd1);
    check("ed_csn_fwd", 32'(bus_rr.flash_csn), 32'd0);
    a_pins = PINS_IDLE;
    cyc("ed_release");
    check("ed_grant_drop", 32'(bus_rr.a_grant), 32'd0);
    for (int i = 0; i < 5; i++) cyc("ed_gap");

    // Ties from reset: A first on both; after A yields during a tie,
    // round-robin hands over to B, fixed priority keeps A.
    reset = 1'b1;
    cyc("tie_rst");
    reset = 1'b0;
    a_req = 1'b1;
    b_req = 1'b1;
    cyc("tie1");
    check("tie1_rr_a", 32'(bus_rr.a_grant), 32'd1);
    check("tie1_fp_a", 32'(bus_fp.a_grant), 32'd1);
    a_pins[4] = 1'b0;
    for (int i = 0; i < 3; i++) cyc("tie1_xfer");
    a_pins[4] = 1'b1;
    a_req     = 1'b0;
    cyc("tie1_release");
    a_req = 1'b1;
    for (int i = 0; i < 5; i++) cyc("tie1_gap");
    check("tie2_rr_b", 32'(bus_rr.b_grant), 32'd1);
    check("tie2_fp_a", 32'(bus_fp.a_grant), 32'd1);
    b_req = 1'b0;
    cyc("tie2_b_release");
    b_req = 1'b1;
    for (int i = 0; i < 5; i++) cyc("tie2_gap");
    check("tie3_rr_a", 32'(bus_rr.a_grant), 32'd1);
    check("tie3_fp_a_kept", 32'(bus_fp.a_grant), 32'd1);

    // Reset in the middle of a B transfer.
    idle_inputs();
    reset = 1'b1;
    cyc("mid_rst0");
    reset = 1'b0;
    b_req = 1'b1;
    cyc("mid_b_req");
    b_pins[4] = 1'b0;
    for (int i = 0; i < 3; i++) cyc("mid_b_xfer");
    check("mid_csn_low", 32'(bus_rr.flash_csn), 32'd0);
    reset = 1'b1;
    cyc("mid_reset");
    check("mid_csn_high", 32'(bus_rr.flash_csn), 32'd1);
    check("mid_b_grant", 32'(bus_rr.b_grant), 32'd0);
    check("mid_busy", 32'(bus_rr.busy), 32'd0);
    reset = 1'b0;
    b_pins = PINS_IDLE;
    a_req  = 1'b1;
    cyc("mid_tie");
    check("mid_tie_a", 32'(bus_rr.a_grant), 32'd1);

    // Randomized traffic, including arbitrary non-owner activity and resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) a_req = ~a_req;
      if ($urandom_range(0, 7) == 0) b_req = ~b_req;
      if ($urandom_range(0, 3) == 0) a_pins[4] = ~a_pins[4];
      if ($urandom_range(0, 3) == 0) b_pins[4] = ~b_pins[4];
      a_pins[3:0] = 4'($urandom);
      b_pins[3:0] = 4'($urandom);
      reset       = ($urandom_range(0, 199) == 0);
      cyc("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flash_spi_arbiter.md
Name: flash_spi_arbiter

Overview:
- Shares the single on-board SPI config flash between two SPI masters.
- Requester A is the computer core's EEPROM port; requester B is the boot/loader path (serial or ESP32-side image loader).
- Grants exclusive ownership and forwards the owner's pins to the flash pin driver, which sits ahead of the USRMCLK primitive.
- Ownership changes only at a transaction boundary, with CSN held high for a guaranteed idle gap, so the two masters can never corrupt each other's SPI transaction.

Parameters:
- C_idle_min, 4: cycles flash_csn is forced high between owners, minimum 1.
- C_rr, 1: 1 = round-robin on simultaneous requests; 0 = fixed priority, A wins.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- a_req  in  1  A requests the flash
- a_grant  out  1  A owns the flash
- a_csn, a_sck, a_mosi, a_holdn, a_wpn  in  1 each  A's SPI outputs
- a_miso  out  1  flash data to A
- b_req, b_grant, b_csn, b_sck, b_mosi, b_holdn, b_wpn, b_miso  same as the A group, for B
- flash_csn, flash_sck, flash_mosi, flash_holdn, flash_wpn  out  1 each  to flash pins / USRMCLK
- flash_miso  in  1  from flash
- busy  out  1  high in any state except IDLE

Behaviour:
- Single clock, synchronous active-high reset.
- States: IDLE, OWN_A, OWN_B, GAP.
- Reset values (registered outputs):
  - a_grant=0, b_grant=0, busy=0
  - flash_csn=1, flash_sck=0, flash_mosi=0, flash_holdn=1, flash_wpn=1
  - state=IDLE, last_served=B, so A wins the first tie.
- Reset mid-transaction: on the next edge flash_csn goes to 1 and grants drop. No draining of the interrupted transaction.
- IDLE:
  - Pins held at their reset values.
  - If a_req or b_req, the winner is chosen:
    - only one requesting: that one;
    - both requesting, C_rr=0: A;
    - both requesting, C_rr=1: the requester not equal to last_served.
  - Next edge: state=OWN_x, x_grant=1, last_served=x.
  - Latency from req sampled high in IDLE to grant high is 1 cycle.
- OWN_x:
  - flash pins are registered copies of x's SPI outputs, 1-cycle delay on every pin.
  - x_miso = flash_miso, combinational.
  - Non-owner's miso = 1. Both misos = 1 outside OWN states.
  - Non-owner's inputs are ignored.
  - Leave only when x_req==0 AND x_csn==1 in the same cycle; next state is GAP.
  - If x_req drops while x_csn==0, stay in OWN_x with grant held until x_csn==1.
- GAP:
  - x_grant=0 on entry. Pins at IDLE values.
  - Down-counter loaded with C_idle_min-1; decrements each cycle; goes to IDLE when it reaches 0.
  - flash_csn stays high for at least C_idle_min cycles, plus 1 IDLE cycle.
  - Requests during GAP are held off and re-evaluated in IDLE.
- Masters must not drive csn low before seeing grant, and must run sck at most clk/4 to absorb the 1-cycle pin delay.
- The counter is sized as clog2(C_idle_min)+1 bits, with no wrap. Counter value in non-GAP states is don't-care but must be reset to 0.
- Owner re-request: a req held continuously by the owner keeps ownership indefinitely. There is no preemption and no timeout.

Test Plan:
- Reset, then idle: reset high 3 cycles → flash_csn=1, flash_sck=0, flash_holdn=1, flash_wpn=1, grants 0, busy 0; a_miso=b_miso=1.
- Single A transaction: a_req=1 at cycle 0 → a_grant=1 at cycle 1. A sends 0x03 plus 3 address bytes at clk/4; flash_mosi/sck/csn follow A with exactly 1-cycle delay; a_miso tracks flash_miso; b_miso=1. a_req=0 with a_csn=1 → a_grant=0 next edge, flash_csn high ≥4 cycles, busy=0 after 5.
- Early req drop: a_req falls while a_csn=0 for 10 more cycles → grant and pin forwarding held until a_csn=1, then GAP.
- Tie, C_rr=1: both req from reset → A granted. A releases with B still requesting, and A re-requests during GAP → B granted after GAP; next tie goes to A. Repeat with C_rr=0 → A wins every tie.
- Non-owner isolation: during OWN_A, toggle b_csn/b_sck/b_mosi every cycle → flash pins match A only; b_grant stays 0.
- Reset mid-transfer: reset asserted during OWN_B with flash_csn=0 → next edge flash_csn=1, b_grant=0, state IDLE; a later tie is granted to A.
